// File: rtl/fmdll_delay_ctrl_if.sv
// Phase-decision input and delay-line control/status bundle for the FMDLL loop filter.
interface fmdll_delay_ctrl_if #(
  parameter int unsigned CODE_W = 6
);
  logic [1:0]        Sel;
  logic              DIV_M;
  logic [CODE_W-1:0] Ctrl_code;
  logic [CODE_W-1:0] Step;
  logic [1:0]        State;
  logic              Lock;
  logic              Sat;
  logic              Upd;

  // Upstream controller / stimulus side
  modport master (
    output Sel, DIV_M,
    input  Ctrl_code, Step, State, Lock, Sat, Upd
  );

  // Loop-filter side
  modport slave (
    input  Sel, DIV_M,
    output Ctrl_code, Step, State, Lock, Sat, Upd
  );
endinterface

// File: rtl/fmdll_delay_ctrl.sv
// FMDLL loop filter: binary-search acquisition of the delay-line code, then
// single-step tracking with lock qualification and run-length unlock.
module fmdll_delay_ctrl #(
  parameter int unsigned CODE_W     = 6,
  parameter int unsigned INIT_CODE  = 32,
  parameter int unsigned INIT_STEP  = 8,
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned UNLOCK_RUN = 3
) (
  input  logic                clk_ext,
  input  logic                rst_n,
  fmdll_delay_ctrl_if.slave   ctrl_if
);

  localparam int unsigned TRK_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned RUN_W = $clog2(UNLOCK_RUN + 1);

  typedef enum logic [1:0] {
    ST_ACQ   = 2'b00,
    ST_TRACK = 2'b01,
    ST_LOCK  = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    DIR_NONE = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DN   = 2'b10
  } dir_e;

  logic              div_m_q;
  logic [CODE_W-1:0] code_q;
  logic [CODE_W-1:0] step_q;
  state_e            state_q;
  logic              lock_q;
  logic              upd_q;
  dir_e              last_dir_q;
  logic [TRK_W-1:0]  trk_cnt_q;
  logic [RUN_W-1:0]  run_cnt_q;

  logic              evt_c;
  dir_e              move_dir_c;
  logic [CODE_W:0]   sum_c;
  logic [CODE_W:0]   diff_c;
  logic [CODE_W-1:0] moved_code_c;
  logic              reversal_c;
  logic [TRK_W-1:0]  trk_inc_c;
  logic [RUN_W-1:0]  run_next_c;

  // Rising edge of DIV_M; the registered copy resets high so a level present at reset release is not an event
  assign evt_c = ctrl_io_divm();

  function automatic logic ctrl_io_divm();
    return ctrl_if.DIV_M & ~div_m_q;
  endfunction

  // Decode the decision, compute the clamped move and direction/counter lookahead
  always_comb begin
    move_dir_c   = DIR_NONE;
    sum_c        = {1'b0, code_q} + {1'b0, step_q};
    diff_c       = {1'b0, code_q} - {1'b0, step_q};
    moved_code_c = code_q;
    reversal_c   = 1'b0;
    trk_inc_c    = trk_cnt_q + TRK_W'(1);
    run_next_c   = '0;

    if (ctrl_if.Sel == 2'b01) begin
      move_dir_c = DIR_UP;
    end else if (ctrl_if.Sel == 2'b10) begin
      move_dir_c = DIR_DN;
    end

    // Carry out means past max, borrow out means below zero
    if (move_dir_c == DIR_UP) begin
      moved_code_c = sum_c[CODE_W] ? '1 : sum_c[CODE_W-1:0];
    end else if (move_dir_c == DIR_DN) begin
      moved_code_c = diff_c[CODE_W] ? '0 : diff_c[CODE_W-1:0];
    end

    reversal_c = (move_dir_c != DIR_NONE) && (last_dir_q != DIR_NONE) &&
                 (move_dir_c != last_dir_q);

    if (reversal_c) begin
      run_next_c = RUN_W'(1);
    end else if (move_dir_c != DIR_NONE) begin
      run_next_c = run_cnt_q + RUN_W'(1);
    end
  end

  // Loop state machine: all control state advances only on an update event
  always_ff @(posedge clk_ext or negedge rst_n) begin
    if (!rst_n) begin
      div_m_q    <= 1'b1;
      code_q     <= CODE_W'(INIT_CODE);
      step_q     <= CODE_W'(INIT_STEP);
      state_q    <= ST_ACQ;
      lock_q     <= 1'b0;
      upd_q      <= 1'b0;
      last_dir_q <= DIR_NONE;
      trk_cnt_q  <= '0;
      run_cnt_q  <= '0;
    end else begin
      div_m_q <= ctrl_if.DIV_M;
      upd_q   <= evt_c;
      if (evt_c) begin
        code_q <= moved_code_c;
        if (move_dir_c != DIR_NONE) begin
          last_dir_q <= move_dir_c;
        end
        unique case (state_q)
          ST_ACQ: begin
            if (reversal_c) begin
              if (step_q > CODE_W'(1)) begin
                step_q <= step_q >> 1;
              end else begin
                state_q   <= ST_TRACK;
                trk_cnt_q <= '0;
              end
            end
          end
          ST_TRACK: begin
            if (reversal_c || (move_dir_c == DIR_NONE)) begin
              if (trk_inc_c == TRK_W'(LOCK_CNT)) begin
                state_q   <= ST_LOCK;
                lock_q    <= 1'b1;
                run_cnt_q <= '0;
                trk_cnt_q <= '0;
              end else begin
                trk_cnt_q <= trk_inc_c;
              end
            end else begin
              trk_cnt_q <= '0;
            end
          end
          ST_LOCK: begin
            if (run_next_c == RUN_W'(UNLOCK_RUN)) begin
              // Drift in one direction means the loop lost lock; restart the search from here
              state_q    <= ST_ACQ;
              lock_q     <= 1'b0;
              step_q     <= CODE_W'(INIT_STEP);
              last_dir_q <= DIR_NONE;
              run_cnt_q  <= '0;
            end else begin
              run_cnt_q <= run_next_c;
            end
          end
          default: begin
            state_q <= ST_ACQ;
          end
        endcase
      end
    end
  end

  // Status outputs; saturation is decoded straight from the code register
  assign ctrl_if.Ctrl_code = code_q;
  assign ctrl_if.Step      = step_q;
  assign ctrl_if.State     = state_q;
  assign ctrl_if.Lock      = lock_q;
  assign ctrl_if.Upd       = upd_q;
  assign ctrl_if.Sat       = (code_q == '0) || (code_q == '1);

endmodule

// File: tb/tb_fmdll_delay_ctrl.sv
// Bench for fmdll_delay_ctrl: integer reference model, per-cycle compare,
// scripted scenarios with literal expectations, then randomized traffic.
module tb_fmdll_delay_ctrl;

  localparam int unsigned CODE_W     = 6;
  localparam int unsigned INIT_CODE  = 32;
  localparam int unsigned INIT_STEP  = 8;
  localparam int unsigned LOCK_CNT   = 4;
  localparam int unsigned UNLOCK_RUN = 3;
  localparam int          MAXC       = (1 << CODE_W) - 1;

  logic clk;
  logic rst_n;

  fmdll_delay_ctrl_if #(.CODE_W(CODE_W)) bus ();

  fmdll_delay_ctrl #(
    .CODE_W(CODE_W), .INIT_CODE(INIT_CODE), .INIT_STEP(INIT_STEP),
    .LOCK_CNT(LOCK_CNT), .UNLOCK_RUN(UNLOCK_RUN)
  ) dut (
    .clk_ext(clk),
    .rst_n  (rst_n),
    .ctrl_if(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: plain integers; dir is +1 up, -1 down, 0 none
  int m_code  = INIT_CODE;
  int m_step  = INIT_STEP;
  int m_state = 0;
  int m_lock  = 0;
  int m_upd   = 0;
  int m_last  = 0;
  int m_trk   = 0;
  int m_run   = 0;
  int m_prev  = 1;

  int n_vec = 0;
  int n_err = 0;
  int upd_seen;

  task automatic m_reset();
    m_code = INIT_CODE; m_step = INIT_STEP; m_state = 0; m_lock = 0;
    m_upd = 0; m_last = 0; m_trk = 0; m_run = 0; m_prev = 1;
  endtask

  task automatic m_event(input logic [1:0] sel);
    int d;
    bit rev;
    d   = (sel == 2'b01) ? 1 : (sel == 2'b10) ? -1 : 0;
    rev = (d != 0) && (m_last != 0) && (d != m_last);
    if (d == 1)  m_code = (m_code + m_step > MAXC) ? MAXC : m_code + m_step;
    if (d == -1) m_code = (m_code - m_step < 0) ? 0 : m_code - m_step;
    if (d != 0)  m_last = d;
    case (m_state)
      0: if (rev) begin
           if (m_step > 1) m_step = m_step / 2;
           else begin m_state = 1; m_trk = 0; end
         end
      1: if (rev || d == 0) begin
           m_trk++;
           if (m_trk == LOCK_CNT) begin m_state = 2; m_lock = 1; m_run = 0; m_trk = 0; end
         end else m_trk = 0;
      default: begin
        if (rev) m_run = 1;
        else if (d != 0) m_run++;
        else m_run = 0;
        if (m_run == UNLOCK_RUN) begin
          m_state = 0; m_lock = 0; m_step = INIT_STEP; m_last = 0; m_run = 0;
        end
      end
    endcase
  endtask

  // Model advances on the same edges as the design
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_reset();
    end else begin
      m_upd = 0;
      if (bus.DIV_M && (m_prev == 0)) begin
        m_event(bus.Sel);
        m_upd = 1;
      end
      m_prev = int'(bus.DIV_M);
    end
  end

  function automatic int m_sat();
    return (m_code == 0 || m_code == MAXC) ? 1 : 0;
  endfunction

  // Per-cycle compare of every output against the model
  task automatic cmp_cycle();
    n_vec++;
    if (bus.Ctrl_code !== CODE_W'(m_code) || bus.Step !== CODE_W'(m_step) ||
        bus.State !== 2'(m_state) || bus.Lock !== 1'(m_lock) ||
        bus.Sat !== 1'(m_sat()) || bus.Upd !== 1'(m_upd)) begin
      n_err++;
      $display("FAIL cycle t=%0t: dut code=%0d step=%0d state=%0d lock=%0b sat=%0b upd=%0b, model code=%0d step=%0d state=%0d lock=%0d sat=%0d upd=%0d",
               $time, bus.Ctrl_code, bus.Step, bus.State, bus.Lock, bus.Sat, bus.Upd,
               m_code, m_step, m_state, m_lock, m_sat(), m_upd);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cmp_cycle();
    if (bus.Upd === 1'b1) upd_seen++;
  endtask

  // Hand-computed expectation applied to both the design and the model
  task automatic lit(input string nm, input int code, input int step,
                     input int st, input int lk, input int sat);
    n_vec++;
    if (bus.Ctrl_code !== CODE_W'(code) || bus.Step !== CODE_W'(step) ||
        bus.State !== 2'(st) || bus.Lock !== 1'(lk) || bus.Sat !== 1'(sat)) begin
      n_err++;
      $display("FAIL %s: dut code=%0d step=%0d state=%0d lock=%0b sat=%0b, expected %0d %0d %0d %0d %0d",
               nm, bus.Ctrl_code, bus.Step, bus.State, bus.Lock, bus.Sat, code, step, st, lk, sat);
    end
    n_vec++;
    if (m_code != code || m_step != step || m_state != st || m_lock != lk || m_sat() != sat) begin
      n_err++;
      $display("FAIL %s(model): code=%0d step=%0d state=%0d lock=%0d, expected %0d %0d %0d %0d",
               nm, m_code, m_step, m_state, m_lock, code, step, st, lk);
    end
  endtask

  task automatic lit_int(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // One DIV_M pulse carrying a decision; Sel is scrambled afterwards to show it is ignored
  task automatic send_event(input logic [1:0] sel);
    tick();
    bus.Sel   = sel;
    bus.DIV_M = 1'b1;
    tick();
    bus.DIV_M = 1'b0;
    bus.Sel   = 2'($urandom_range(0, 3));
  endtask

  task automatic do_reset();
    tick();
    rst_n     = 1'b0;
    bus.DIV_M = 1'b0;
    bus.Sel   = 2'b00;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  localparam logic [1:0] UP = 2'b01;
  localparam logic [1:0] DN = 2'b10;

  initial begin
    rst_n     = 1'b0;
    bus.Sel   = 2'b00;
    bus.DIV_M = 1'b0;
    upd_seen  = 0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    lit("reset", 32, 8, 0, 0, 0);
    lit_int("reset_upd", int'(bus.Upd), 0);

    // Binary-search acquisition into TRACK
    send_event(UP); lit("acq1", 40, 8, 0, 0, 0);
    send_event(UP); lit("acq2", 48, 8, 0, 0, 0);
    send_event(DN); lit("acq3", 40, 4, 0, 0, 0);
    send_event(UP); lit("acq4", 44, 2, 0, 0, 0);
    send_event(DN); lit("acq5", 42, 1, 0, 0, 0);
    send_event(UP); lit("acq6", 43, 1, 1, 0, 0);

    // Four qualifying reversals lock
    send_event(DN); lit("trk1", 42, 1, 1, 0, 0);
    send_event(UP); lit("trk2", 43, 1, 1, 0, 0);
    send_event(DN); lit("trk3", 42, 1, 1, 0, 0);
    send_event(UP); lit("trk4", 43, 1, 2, 1, 0);

    // Three moves the same way drop lock, code kept
    send_event(DN); lit("unl1", 42, 1, 2, 1, 0);
    send_event(DN); lit("unl2", 41, 1, 2, 1, 0);
    send_event(DN); lit("unl3", 40, 8, 0, 0, 0);

    // Saturation at max code
    do_reset();
    send_event(UP); lit("sat1", 40, 8, 0, 0, 0);
    send_event(UP); lit("sat2", 48, 8, 0, 0, 0);
    send_event(UP); lit("sat3", 56, 8, 0, 0, 0);
    send_event(UP); lit("sat4", 63, 8, 0, 0, 1);
    send_event(UP); lit("sat5", 63, 8, 0, 0, 1);

    // DIV_M held high with Sel toggling: one event only
    do_reset();
    upd_seen  = 0;
    bus.Sel   = UP;
    bus.DIV_M = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      bus.Sel = ~bus.Sel;
    end
    bus.DIV_M = 1'b0;
    tick();
    tick();
    lit("hold_high", 40, 8, 0, 0, 0);
    lit_int("hold_high_upd_pulses", upd_seen, 1);

    // DIV_M already high at reset release is not an event
    tick();
    rst_n     = 1'b0;
    bus.DIV_M = 1'b1;
    bus.Sel   = UP;
    tick();
    upd_seen = 0;
    rst_n    = 1'b1;
    tick();
    tick();
    lit("divm_at_release", 32, 8, 0, 0, 0);
    lit_int("divm_at_release_upd", upd_seen, 0);
    bus.DIV_M = 1'b0;

    // Asynchronous reset mid-acquisition
    send_event(UP);
    send_event(UP);
    send_event(DN); lit("pre_async", 40, 4, 0, 0, 0);
    tick();
    #2 rst_n = 1'b0;
    #1;
    lit("async_reset", 32, 8, 0, 0, 0);
    lit_int("async_reset_upd", int'(bus.Upd), 0);
    tick();
    rst_n = 1'b1;

    // Randomized traffic with occasional resets
    for (int i = 0; i < 4000; i++) begin
      tick();
      if (rst_n == 1'b0) begin
        rst_n = 1'b1;
      end else if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
      end
      bus.Sel = 2'($urandom_range(0, 3));
      if (bus.DIV_M) bus.DIV_M = ($urandom_range(0, 1) == 0) ? 1'b1 : 1'b0;
      else           bus.DIV_M = ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0;
    end
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
